// File: rtl/wb_pkg.sv
// Shared definitions for the write-back / commit stage: exception codes,
// FSM state encoding and the debug trace entry layout.
package wb_pkg;

  // Exception codes carried from MEM to the CSR unit.
  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;
  localparam logic [5:0] ECODE_IPE = 6'h0E;

  // Commit FSM: RUN retires instructions, FLUSH holds the pipe flush.
  typedef enum logic [0:0] {
    WB_RUN   = 1'b0,
    WB_FLUSH = 1'b1
  } wb_state_e;

  // Plain-vector state constants so the state register stays a logic vector.
  localparam logic [0:0] ST_RUN   = WB_RUN;
  localparam logic [0:0] ST_FLUSH = WB_FLUSH;

  // Default datapath widths of the stage.
  localparam int WB_PC_W    = 32;
  localparam int WB_REG_AW  = 5;
  localparam int WB_DATA_W  = 32;
  localparam int WB_WEN_W   = 4;

  // Trace entry layout at default widths: {pc, wen, wnum, wdata}.
  typedef struct packed {
    logic [WB_PC_W-1:0]   pc;
    logic [WB_WEN_W-1:0]  wen;
    logic [WB_REG_AW-1:0] wnum;
    logic [WB_DATA_W-1:0] wdata;
  } wb_trace_entry_t;

  // Trace byte-enable style write flag: one bit per byte of a 32-bit word.
  function automatic logic [WB_WEN_W-1:0] trace_wen(input logic we);
    return {WB_WEN_W{we}};
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Small synchronous FIFO buffering debug trace entries between the commit
// point and the trace consumer. DEPTH must be a power of two (>= 2).
// Writing while full is accepted only when a pop happens the same cycle.
module wb_trace_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 73
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  // Pointer bookkeeping; the extra MSB separates full from empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Entry storage; contents are qualified by the pointers so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_commit_stage.sv
// Write-back / commit stage: last pipe stage after MEM. Retires one
// instruction per cycle into the register file, commits exceptions and ERTN
// to the external CSR unit, sequences the pipeline flush and counts retired
// instructions.
// Build option: define WB_TRACE_FIFO_EN to place a trace FIFO between the
// commit point and the debug_wb_* port (stalls commit when it fills up).
module wb_commit_stage
  import wb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int PC_W         = 32,
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int TRACE_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ms_to_ws_valid,
  input  logic [PC_W-1:0]   ms_pc,
  input  logic              ms_gr_we,
  input  logic [REG_AW-1:0] ms_dest,
  input  logic [DATA_W-1:0] ms_result,
  input  logic              ms_csr_re,
  input  logic              ms_ex,
  input  logic [5:0]        ms_ecode,
  input  logic [8:0]        ms_esubcode,
  input  logic              ms_ertn,
  input  logic [DATA_W-1:0] csr_rvalue,
  input  logic [PC_W-1:0]   csr_target,
  input  logic              debug_ready,
  output logic              ws_allowin,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_ex,
  output logic [5:0]        wb_ecode,
  output logic [8:0]        wb_esubcode,
  output logic [PC_W-1:0]   wb_pc,
  output logic              ertn_flush,
  output logic              ws_flush_pipe,
  output logic [PC_W-1:0]   ws_flush_pc,
  output logic [63:0]       retired_cnt,
  output logic [PC_W-1:0]   debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [REG_AW-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  // Control state
  logic            ws_valid;
  logic [0:0]      state;
  logic [FC_W-1:0] flush_cnt;

  // Instruction fields latched from MEM
  logic [PC_W-1:0]   ws_pc_p0;
  logic              ws_gr_we_p0;
  logic [REG_AW-1:0] ws_dest_p0;
  logic [DATA_W-1:0] ws_result_p0;
  logic              ws_csr_re_p0;
  logic              ws_ex_p0;
  logic [5:0]        ws_ecode_p0;
  logic [8:0]        ws_esubcode_p0;
  logic              ws_ertn_p0;
  logic [PC_W-1:0]   flush_pc_p0;

  logic              ws_ready_go;
  logic              in_run;
  logic              commit;
  logic              commit_flush;
  logic              commit_norm;
  logic [DATA_W-1:0] ws_wdata;

  assign in_run       = (state == ST_RUN);
  assign ws_allowin   = in_run && (!ws_valid || ws_ready_go);
  assign commit       = ws_valid && ws_ready_go && in_run;
  assign commit_flush = commit && (ws_ex_p0 || ws_ertn_p0);
  assign commit_norm  = commit && !ws_ex_p0 && !ws_ertn_p0;
  assign ws_wdata     = ws_csr_re_p0 ? csr_rvalue : ws_result_p0;

  // Register file write port, quiet unless a normal commit writes a GR
  assign rf_we    = commit_norm && (ws_gr_we_p0 || ws_csr_re_p0);
  assign rf_waddr = rf_we ? ws_dest_p0 : '0;
  assign rf_wdata = rf_we ? ws_wdata : '0;

  // CSR commit pulses; an exception outranks ERTN on the same instruction
  assign wb_ex       = commit && ws_ex_p0;
  assign wb_ecode    = wb_ex ? ws_ecode_p0 : '0;
  assign wb_esubcode = wb_ex ? ws_esubcode_p0 : '0;
  assign wb_pc       = wb_ex ? ws_pc_p0 : '0;
  assign ertn_flush  = commit && ws_ertn_p0 && !ws_ex_p0;

  // Flush asserted on the committing cycle and throughout FLUSH
  assign ws_flush_pipe = commit_flush || (state == ST_FLUSH);
  always_comb begin
    ws_flush_pc = '0;
    if (commit_flush)           ws_flush_pc = csr_target;
    else if (state == ST_FLUSH) ws_flush_pc = flush_pc_p0;
  end

  // Valid bit and flush sequencing FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid  <= 1'b0;
      state     <= ST_RUN;
      flush_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (commit_flush) begin
            ws_valid  <= 1'b0;
            flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
            if (FLUSH_CYCLES > 1) state <= ST_FLUSH;
          end else if (ws_allowin) begin
            ws_valid <= ms_to_ws_valid;
          end
        end
        default: begin
          ws_valid <= 1'b0;
          if (flush_cnt <= FC_W'(1)) begin
            flush_cnt <= '0;
            state     <= ST_RUN;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // Retired-instruction counter, excepting/ERTN commits excluded
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) retired_cnt <= '0;
    else if (commit_norm) retired_cnt <= retired_cnt + 64'd1;
  end

  // MEM to WB pipeline register; fields are qualified by ws_valid
  always_ff @(posedge clk) begin
    if (ws_allowin && ms_to_ws_valid) begin
      ws_pc_p0       <= ms_pc;
      ws_gr_we_p0    <= ms_gr_we;
      ws_dest_p0     <= ms_dest;
      ws_result_p0   <= ms_result;
      ws_csr_re_p0   <= ms_csr_re;
      ws_ex_p0       <= ms_ex;
      ws_ecode_p0    <= ms_ecode;
      ws_esubcode_p0 <= ms_esubcode;
      ws_ertn_p0     <= ms_ertn;
    end
  end

  // Redirect target held for the remaining flush cycles
  always_ff @(posedge clk) begin
    if (commit_flush) flush_pc_p0 <= csr_target;
  end

`ifdef WB_TRACE_FIFO_EN
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [3:0]        wen;
    logic [REG_AW-1:0] wnum;
    logic [DATA_W-1:0] wdata;
  } trace_entry_t;

  trace_entry_t trace_in;
  trace_entry_t trace_head;
  logic         fifo_empty;
  logic         fifo_full;
  logic         fifo_pop;

  assign trace_in.pc    = ws_pc_p0;
  assign trace_in.wen   = trace_wen(rf_we);
  assign trace_in.wnum  = ws_dest_p0;
  assign trace_in.wdata = ws_wdata;

  // A full FIFO only blocks commit when the head is not leaving this cycle
  assign fifo_pop    = debug_ready && !fifo_empty;
  assign ws_ready_go = !fifo_full || debug_ready;

  wb_trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .W     ($bits(trace_entry_t))
  ) u_trace_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (commit),
    .din    (trace_in),
    .pop    (fifo_pop),
    .dout   (trace_head),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign debug_wb_pc       = fifo_empty ? '0 : trace_head.pc;
  assign debug_wb_rf_wen   = fifo_empty ? '0 : trace_head.wen;
  assign debug_wb_rf_wnum  = fifo_empty ? '0 : trace_head.wnum;
  assign debug_wb_rf_wdata = fifo_empty ? '0 : trace_head.wdata;
`else
  logic unused_debug_ready;
  localparam int unused_trace_depth = TRACE_DEPTH;

  assign unused_debug_ready = debug_ready;
  assign ws_ready_go        = 1'b1;

  // Trace follows the commit point directly
  assign debug_wb_pc       = commit ? ws_pc_p0 : '0;
  assign debug_wb_rf_wen   = trace_wen(rf_we);
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage: reset, back-to-back retire, CSR read,
// exception and ERTN flush sequencing, and (with WB_TRACE_FIFO_EN) trace stall.
module tb_wb_commit_stage;
  import wb_pkg::*;

  localparam int DATA_W       = 32;
  localparam int PC_W         = 32;
  localparam int REG_AW       = 5;
  localparam int FLUSH_CYCLES = 2;
  localparam int TRACE_DEPTH  = 4;

  logic              clk;
  logic              resetn;
  logic              ms_to_ws_valid;
  logic [PC_W-1:0]   ms_pc;
  logic              ms_gr_we;
  logic [REG_AW-1:0] ms_dest;
  logic [DATA_W-1:0] ms_result;
  logic              ms_csr_re;
  logic              ms_ex;
  logic [5:0]        ms_ecode;
  logic [8:0]        ms_esubcode;
  logic              ms_ertn;
  logic [DATA_W-1:0] csr_rvalue;
  logic [PC_W-1:0]   csr_target;
  logic              debug_ready;
  logic              ws_allowin;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              wb_ex;
  logic [5:0]        wb_ecode;
  logic [8:0]        wb_esubcode;
  logic [PC_W-1:0]   wb_pc;
  logic              ertn_flush;
  logic              ws_flush_pipe;
  logic [PC_W-1:0]   ws_flush_pc;
  logic [63:0]       retired_cnt;
  logic [PC_W-1:0]   debug_wb_pc;
  logic [3:0]        debug_wb_rf_wen;
  logic [REG_AW-1:0] debug_wb_rf_wnum;
  logic [DATA_W-1:0] debug_wb_rf_wdata;

  int errors = 0;
  int checks = 0;

  wb_commit_stage #(
    .DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW),
    .FLUSH_CYCLES(FLUSH_CYCLES), .TRACE_DEPTH(TRACE_DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_gr_we(ms_gr_we),
    .ms_dest(ms_dest), .ms_result(ms_result), .ms_csr_re(ms_csr_re),
    .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode),
    .ms_ertn(ms_ertn), .csr_rvalue(csr_rvalue), .csr_target(csr_target),
    .debug_ready(debug_ready), .ws_allowin(ws_allowin),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc), .ertn_flush(ertn_flush), .ws_flush_pipe(ws_flush_pipe),
    .ws_flush_pc(ws_flush_pc), .retired_cnt(retired_cnt),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic clear_in;
    ms_to_ws_valid = 1'b0; ms_pc = '0; ms_gr_we = 1'b0; ms_dest = '0;
    ms_result = '0; ms_csr_re = 1'b0; ms_ex = 1'b0; ms_ecode = '0;
    ms_esubcode = '0; ms_ertn = 1'b0;
  endtask

  task automatic set_instr(input logic [PC_W-1:0] pc, input logic gr_we,
                           input logic [REG_AW-1:0] dest, input logic [DATA_W-1:0] res,
                           input logic csr_re, input logic ex, input logic ertn);
    ms_to_ws_valid = 1'b1; ms_pc = pc; ms_gr_we = gr_we; ms_dest = dest;
    ms_result = res; ms_csr_re = csr_re; ms_ex = ex; ms_ertn = ertn;
    ms_ecode = '0; ms_esubcode = '0;
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; clear_in; debug_ready = 1'b1; csr_rvalue = '0; csr_target = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    set_instr(32'h1C000100, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0, 1'b0);
    next_cycle;
    set_instr(32'h1C000104, 1'b1, 5'd10, 32'hAA, 1'b0, 1'b0, 1'b0);
    next_cycle;
    clear_in;
    @(negedge clk);
    checks++;
    if (retired_cnt !== 64'd1) begin errors++; $display("FAIL pre_reset_cnt: got %0d want 1", retired_cnt); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
      errors++; $display("FAIL reset_rf: we=%0b addr=%0d data=%h want 0", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (retired_cnt !== 64'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", retired_cnt); end
    checks++;
    if (wb_ex !== 1'b0 || ertn_flush !== 1'b0 || ws_flush_pipe !== 1'b0 || ws_flush_pc !== '0 || wb_pc !== '0) begin
      errors++; $display("FAIL reset_ctl: ex=%0b ertn=%0b flush=%0b fpc=%h want 0", wb_ex, ertn_flush, ws_flush_pipe, ws_flush_pc);
    end
    checks++;
    if (debug_wb_rf_wen !== 4'h0 || debug_wb_pc !== '0) begin
      errors++; $display("FAIL reset_trace: wen=%h pc=%h want 0", debug_wb_rf_wen, debug_wb_pc);
    end
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (ws_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %0b want 1", ws_allowin); end
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_idle_we: got %0b want 0", rf_we); end
  endtask

  task automatic test_back_to_back;
    logic [REG_AW-1:0] exp_addr [3];
    logic [DATA_W-1:0] exp_data [3];
    logic [PC_W-1:0]   exp_pc   [3];
    exp_addr = '{5'd1, 5'd2, 5'd3};
    exp_data = '{32'hA, 32'hB, 32'hC};
    exp_pc   = '{32'h1C000000, 32'h1C000004, 32'h1C000008};
    next_cycle;
    set_instr(exp_pc[0], 1'b1, exp_addr[0], exp_data[0], 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      next_cycle;
      if (i < 2) set_instr(exp_pc[i+1], 1'b1, exp_addr[i+1], exp_data[i+1], 1'b0, 1'b0, 1'b0);
      else clear_in;
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== exp_addr[i] || rf_wdata !== exp_data[i]) begin
        errors++;
        $display("FAIL b2b_write%0d: we=%0b addr=%0d data=%h want 1/%0d/%h",
                 i, rf_we, rf_waddr, rf_wdata, exp_addr[i], exp_data[i]);
      end
`ifndef WB_TRACE_FIFO_EN
      checks++;
      if (debug_wb_pc !== exp_pc[i] || debug_wb_rf_wen !== 4'hF) begin
        errors++; $display("FAIL b2b_trace%0d: pc=%h wen=%h want %h/f", i, debug_wb_pc, debug_wb_rf_wen, exp_pc[i]);
      end
`endif
    end
    next_cycle;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || retired_cnt !== 64'd3) begin
      errors++; $display("FAIL b2b_end: we=%0b cnt=%0d want 0/3", rf_we, retired_cnt);
    end
  endtask

  task automatic test_csr_read;
    next_cycle;
    set_instr(32'h1C000010, 1'b0, 5'd5, 32'hDEAD, 1'b1, 1'b0, 1'b0);
    csr_rvalue = 32'h1234;
    next_cycle;
    clear_in;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
      errors++; $display("FAIL csr_read: we=%0b addr=%0d data=%h want 1/5/1234", rf_we, rf_waddr, rf_wdata);
    end
    next_cycle;
    @(negedge clk);
    checks++;
    if (retired_cnt !== 64'd4) begin errors++; $display("FAIL csr_cnt: got %0d want 4", retired_cnt); end
  endtask

  task automatic test_syscall;
    next_cycle;
    set_instr(32'h1C000020, 1'b1, 5'd6, 32'h66, 1'b0, 1'b1, 1'b0);
    ms_ecode = ECODE_SYS; ms_esubcode = 9'd0;
    csr_target = 32'h1C008000;
    next_cycle;
    clear_in;
    @(negedge clk);
    checks++;
    if (wb_ex !== 1'b1 || wb_ecode !== 6'h0B || wb_pc !== 32'h1C000020) begin
      errors++; $display("FAIL sys_commit: ex=%0b ecode=%h pc=%h want 1/0b/1c000020", wb_ex, wb_ecode, wb_pc);
    end
    checks++;
    if (rf_we !== 1'b0 || ws_flush_pipe !== 1'b1 || ws_flush_pc !== 32'h1C008000) begin
      errors++; $display("FAIL sys_flush0: we=%0b flush=%0b fpc=%h want 0/1/1c008000", rf_we, ws_flush_pipe, ws_flush_pc);
    end
    next_cycle;
    @(negedge clk);
    checks++;
    if (wb_ex !== 1'b0 || ws_flush_pipe !== 1'b1 || ws_allowin !== 1'b0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL sys_flush1: ex=%0b flush=%0b allowin=%0b we=%0b want 0/1/0/0", wb_ex, ws_flush_pipe, ws_allowin, rf_we);
    end
    next_cycle;
    @(negedge clk);
    checks++;
    if (ws_flush_pipe !== 1'b0 || ws_allowin !== 1'b1 || retired_cnt !== 64'd4) begin
      errors++; $display("FAIL sys_done: flush=%0b allowin=%0b cnt=%0d want 0/1/4", ws_flush_pipe, ws_allowin, retired_cnt);
    end
  endtask

  task automatic test_ertn;
    next_cycle;
    set_instr(32'h1C000030, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    csr_target = 32'h1C000400;
    next_cycle;
    set_instr(32'h1C000034, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (ertn_flush !== 1'b1 || wb_ex !== 1'b0 || rf_we !== 1'b0 || ws_flush_pc !== 32'h1C000400) begin
      errors++; $display("FAIL ertn_commit: ertn=%0b ex=%0b we=%0b fpc=%h want 1/0/0/1c000400", ertn_flush, wb_ex, rf_we, ws_flush_pc);
    end
    next_cycle;
    @(negedge clk);
    checks++;
    if (ertn_flush !== 1'b0 || ws_allowin !== 1'b0 || rf_we !== 1'b0 || ws_flush_pipe !== 1'b1) begin
      errors++; $display("FAIL ertn_flush1: ertn=%0b allowin=%0b we=%0b flush=%0b want 0/0/0/1", ertn_flush, ws_allowin, rf_we, ws_flush_pipe);
    end
    next_cycle;
    clear_in;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || ws_flush_pipe !== 1'b0) begin
      errors++; $display("FAIL ertn_resume: we=%0b flush=%0b want 0/0", rf_we, ws_flush_pipe);
    end
    next_cycle;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || retired_cnt !== 64'd4) begin
      errors++; $display("FAIL ertn_held: we=%0b cnt=%0d want 0/4", rf_we, retired_cnt);
    end
  endtask

  task automatic test_ex_over_ertn;
    next_cycle;
    set_instr(32'h1C000040, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1);
    ms_ecode = ECODE_BRK;
    next_cycle;
    clear_in;
    @(negedge clk);
    checks++;
    if (wb_ex !== 1'b1 || ertn_flush !== 1'b0 || wb_ecode !== 6'h0C) begin
      errors++; $display("FAIL ex_prio: ex=%0b ertn=%0b ecode=%h want 1/0/0c", wb_ex, ertn_flush, wb_ecode);
    end
    next_cycle;
    next_cycle;
    @(negedge clk);
    checks++;
    if (ws_flush_pipe !== 1'b0 || retired_cnt !== 64'd4) begin
      errors++; $display("FAIL ex_prio_done: flush=%0b cnt=%0d want 0/4", ws_flush_pipe, retired_cnt);
    end
  endtask

`ifdef WB_TRACE_FIFO_EN
  task automatic test_trace_stall;
    logic [PC_W-1:0] tpc [6];
    int idx;
    int wr;
    int pop;
    logic hs;
    for (int i = 0; i < 6; i++) tpc[i] = 32'h1C001000 + 32'(4 * i);
    idx = 0; wr = 0; pop = 0;
    next_cycle;
    debug_ready = 1'b0;
    set_instr(tpc[0], 1'b1, 5'd1, 32'h100, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (rf_we === 1'b1) wr++;
      hs = ws_allowin && ms_to_ws_valid;
      next_cycle;
      if (hs) begin
        idx++;
        if (idx < 6) set_instr(tpc[idx], 1'b1, 5'(idx + 1), 32'(32'h100 + idx), 1'b0, 1'b0, 1'b0);
        else clear_in;
      end
    end
    checks++;
    if (wr !== 4) begin errors++; $display("FAIL trace_stall_writes: got %0d want 4", wr); end
    @(negedge clk);
    checks++;
    if (ws_allowin !== 1'b0 || debug_wb_pc !== tpc[0] || debug_wb_rf_wen !== 4'hF) begin
      errors++; $display("FAIL trace_stall_state: allowin=%0b pc=%h wen=%h want 0/%h/f", ws_allowin, debug_wb_pc, debug_wb_rf_wen, tpc[0]);
    end
    next_cycle;
    debug_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (rf_we === 1'b1) wr++;
      if (debug_wb_rf_wen !== 4'h0) begin
        checks++;
        if (pop >= 6) begin
          errors++; $display("FAIL trace_extra: pc=%h beyond 6 entries", debug_wb_pc);
        end else if (debug_wb_pc !== tpc[pop]) begin
          errors++; $display("FAIL trace_order%0d: pc=%h want %h", pop, debug_wb_pc, tpc[pop]);
        end
        pop++;
      end
      hs = ws_allowin && ms_to_ws_valid;
      next_cycle;
      if (hs) begin
        idx++;
        if (idx < 6) set_instr(tpc[idx], 1'b1, 5'(idx + 1), 32'(32'h100 + idx), 1'b0, 1'b0, 1'b0);
        else clear_in;
      end
    end
    checks++;
    if (wr !== 6 || pop !== 6) begin
      errors++; $display("FAIL trace_drain: writes=%0d pops=%0d want 6/6", wr, pop);
    end
  endtask
`endif

  task automatic test_reset_mid_flush;
    next_cycle;
    set_instr(32'h1C000050, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    ms_ecode = ECODE_SYS;
    csr_target = 32'h1C008000;
    next_cycle;
    clear_in;
    @(negedge clk);
    next_cycle;
    @(negedge clk);
    checks++;
    if (ws_flush_pipe !== 1'b1) begin errors++; $display("FAIL midflush_pre: flush=%0b want 1", ws_flush_pipe); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (ws_flush_pipe !== 1'b0 || ws_flush_pc !== '0 || retired_cnt !== 64'd0) begin
      errors++; $display("FAIL midflush_reset: flush=%0b fpc=%h cnt=%0d want 0/0/0", ws_flush_pipe, ws_flush_pc, retired_cnt);
    end
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (ws_allowin !== 1'b1 || ws_flush_pipe !== 1'b0) begin
      errors++; $display("FAIL midflush_after: allowin=%0b flush=%0b want 1/0", ws_allowin, ws_flush_pipe);
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_csr_read;
    test_syscall;
    test_ertn;
    test_ex_over_ertn;
`ifdef WB_TRACE_FIFO_EN
    test_trace_stall;
`endif
    test_reset_mid_flush;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
